// File: rtl/audio_pkg.sv
// Shared constants for the audio output chain: sample width, I2S frame geometry, word-select levels.
package audio_pkg;
    localparam int   SAMPLE_W        = 16;
    localparam int   SLOTS_PER_FRAME = 32;
    localparam logic I2S_LEFT        = 1'b0;
    localparam logic I2S_RIGHT       = 1'b1;
endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: produces bclk from clk and a strobe marking the clk edge where bclk falls.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bclk,
    output logic fall_evt
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          div_wrap;

    assign div_wrap = (div_cnt == CW'(CLK_DIV - 1));
    // Combinational so the slot logic updates on the same edge that drops bclk.
    assign fall_evt = enable && div_wrap && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_dac_transmitter.sv
// Philips-I2S serializer: one mono sample per frame duplicated into both slots, with a one-deep holding buffer.
module i2s_dac_transmitter #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       sample_tick,
    output logic                       underrun,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata
);
    import audio_pkg::*;

    localparam int SLOT_W = $clog2(SLOTS_PER_FRAME);
    localparam int IDX_W  = $clog2(SAMPLE_W);

    logic                fall_evt;
    logic [SLOT_W-1:0]   slot;
    logic [SLOT_W-1:0]   slot_nxt;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] hold_buf;
    logic [SAMPLE_W-1:0] last_word;
    logic [SAMPLE_W-1:0] load_word;
    logic [SAMPLE_W-1:0] tx_word;
    logic [IDX_W-1:0]    bit_idx;
    logic                buf_full;
    logic                frame_load;
    logic                accept;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    always_comb begin
        slot_nxt   = slot + 1'b1;
        frame_load = fall_evt && (slot == SLOT_W'(SLOTS_PER_FRAME - 1));
        accept     = in_valid && in_ready;
        load_word  = buf_full ? hold_buf : last_word;
        // On a load the MSB of the incoming word must leave in the same cycle.
        tx_word    = frame_load ? load_word : word;
        bit_idx    = IDX_W'(SAMPLE_W - 1) - slot_nxt[IDX_W-1:0];
    end

    assign in_ready = !buf_full || frame_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= '1;
            word        <= '0;
            lrclk       <= I2S_LEFT;
            sdata       <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= frame_load;
            underrun    <= frame_load && !buf_full;
            if (!enable) begin
                slot  <= '1;
                lrclk <= I2S_LEFT;
                sdata <= 1'b0;
            end else if (fall_evt) begin
                slot  <= slot_nxt;
                // Word select leads each MSB by one bit clock.
                lrclk <= ((slot_nxt >= SLOT_W'(SAMPLE_W - 1)) &&
                          (slot_nxt != SLOT_W'(SLOTS_PER_FRAME - 1))) ? I2S_RIGHT : I2S_LEFT;
                sdata <= tx_word[bit_idx];
                if (frame_load) begin
                    word <= load_word;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_buf  <= '0;
            last_word <= '0;
            buf_full  <= 1'b0;
        end else begin
            if (accept) begin
                hold_buf <= in_sample;
            end
            if (frame_load && buf_full) begin
                last_word <= hold_buf;
            end
            if (accept) begin
                buf_full <= 1'b1;
            end else if (frame_load) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule
